// File: rtl/wb_regfile.sv
// rtl/wb_regfile.sv - writeback result select, 32-entry register file with same-cycle bypass, commit counter
// x0 is never stored; decode reads see the value being committed this cycle through the bypass.
module wb_regfile #(
  parameter int XLEN = 32,
  parameter int NREG = 32,
  localparam int AW = $clog2(NREG)
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            RegWriteW,
  input  logic            MemWriteW,
  input  logic [1:0]      ResultSrcW,
  input  logic [AW-1:0]   RdW,
  input  logic [XLEN-1:0] ALUResultW,
  input  logic [XLEN-1:0] ReadDataW,
  input  logic [XLEN-1:0] PCPlus4W,
  input  logic [AW-1:0]   A1,
  input  logic [AW-1:0]   A2,
  output logic [XLEN-1:0] RD1,
  output logic [XLEN-1:0] RD2,
  output logic [XLEN-1:0] ResultW,
  output logic [31:0]     WriteCount
);

  logic [XLEN-1:0] regs [NREG];
  logic [31:0]     writeCnt;
  logic            commit;
  logic            unusedMemWrite;

  // Stores are handled in the memory stage; nothing here depends on them.
  assign unusedMemWrite = MemWriteW;

  always_comb begin
    ResultW = ALUResultW;
    unique case (ResultSrcW)
      2'b01:   ResultW = ReadDataW;
      2'b10:   ResultW = PCPlus4W;
      default: ResultW = ALUResultW;
    endcase
  end

  assign commit = RegWriteW && (RdW != '0);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < NREG; i++) regs[i] <= '0;
      writeCnt <= '0;
    end else if (commit) begin
      regs[RdW] <= ResultW;
      writeCnt  <= writeCnt + 32'd1;
    end
  end

  always_comb begin
    RD1 = '0;
    RD2 = '0;
    if (A1 != '0) RD1 = (commit && (A1 == RdW)) ? ResultW : regs[A1];
    if (A2 != '0) RD2 = (commit && (A2 == RdW)) ? ResultW : regs[A2];
  end

  assign WriteCount = writeCnt;

endmodule

// File: tb/tb_wb_regfile.sv
// tb/tb_wb_regfile.sv - directed bench for wb_regfile
// Inputs change on the falling edge; registered state is sampled 1 unit after the rising edge.
module tb_wb_regfile;

  logic        clk = 1'b0;
  logic        reset;
  logic        RegWriteW, MemWriteW;
  logic [1:0]  ResultSrcW;
  logic [4:0]  RdW, A1, A2;
  logic [31:0] ALUResultW, ReadDataW, PCPlus4W;
  logic [31:0] RD1, RD2, ResultW, WriteCount;

  int tests = 0;
  int fails = 0;

  wb_regfile dut (
    .clk(clk), .reset(reset),
    .RegWriteW(RegWriteW), .MemWriteW(MemWriteW), .ResultSrcW(ResultSrcW),
    .RdW(RdW), .ALUResultW(ALUResultW), .ReadDataW(ReadDataW), .PCPlus4W(PCPlus4W),
    .A1(A1), .A2(A2), .RD1(RD1), .RD2(RD2), .ResultW(ResultW), .WriteCount(WriteCount)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed 0x%08h expected 0x%08h", tag, obs, exp);
    end
  endtask

  task automatic idle();
    RegWriteW = 0; MemWriteW = 0; ResultSrcW = 2'b00; RdW = 0;
    ALUResultW = 0; ReadDataW = 0; PCPlus4W = 0;
  endtask

  task automatic commitAlu(input logic [4:0] rd, input logic [31:0] val);
    @(negedge clk);
    idle();
    RegWriteW = 1; RdW = rd; ALUResultW = val;
    @(posedge clk); #1;
  endtask

  initial begin
    idle();
    A1 = 5; A2 = 0;
    reset = 1;
    #2;
    check("reset_rd1", RD1, 32'h0);
    check("reset_count", WriteCount, 32'h0);
    @(negedge clk); reset = 0;

    // Write x5, then pulse reset mid-cycle
    commitAlu(5, 32'h1234);
    @(negedge clk); idle(); #1;
    check("x5_written", RD1, 32'h1234);
    check("x5_count", WriteCount, 32'd1);
    #2 reset = 1; #1;
    check("async_reset_rd1", RD1, 32'h0);
    check("async_reset_count", WriteCount, 32'h0);
    @(negedge clk); reset = 0;

    // Source select into x1..x4
    @(negedge clk); idle();
    RegWriteW = 1; RdW = 1; ResultSrcW = 2'b00; ALUResultW = 32'hA5A5A5A5;
    @(posedge clk); #1;
    @(negedge clk); idle();
    RegWriteW = 1; RdW = 2; ResultSrcW = 2'b01; ReadDataW = 32'hDEADBEEF; ALUResultW = 32'h1;
    #1 check("resultw_load", ResultW, 32'hDEADBEEF);
    @(posedge clk); #1;
    @(negedge clk); idle();
    RegWriteW = 1; RdW = 3; ResultSrcW = 2'b10; PCPlus4W = 32'h104; ALUResultW = 32'h2;
    #1 check("resultw_pc4", ResultW, 32'h104);
    @(posedge clk); #1;
    @(negedge clk); idle();
    RegWriteW = 1; RdW = 4; ResultSrcW = 2'b11; ALUResultW = 32'h77; ReadDataW = 32'h3; PCPlus4W = 32'h4;
    #1 check("resultw_reserved", ResultW, 32'h77);
    @(posedge clk); #1;
    @(negedge clk); idle();
    A1 = 1; A2 = 2; #1;
    check("x1_alu", RD1, 32'hA5A5A5A5);
    check("x2_load", RD2, 32'hDEADBEEF);
    A1 = 3; A2 = 4; #1;
    check("x3_pc4", RD1, 32'h104);
    check("x4_reserved", RD2, 32'h77);
    check("count_after_4", WriteCount, 32'd4);

    // x0 stays zero
    @(negedge clk); idle();
    RegWriteW = 1; RdW = 0; ALUResultW = 32'hFFFFFFFF; A1 = 0; A2 = 0; #1;
    check("x0_same_cycle", RD1, 32'h0);
    check("x0_resultw", ResultW, 32'hFFFFFFFF);
    @(posedge clk); #1;
    @(negedge clk); idle(); #1;
    check("x0_next_cycle", RD1, 32'h0);
    check("x0_count", WriteCount, 32'd4);

    // Bypass on x7
    commitAlu(7, 32'h10);
    @(negedge clk); idle();
    RdW = 7; ALUResultW = 32'h20; A1 = 7; A2 = 7; #1;
    check("nobypass_rd1", RD1, 32'h10);
    check("nobypass_rd2", RD2, 32'h10);
    RegWriteW = 1; #1;
    check("bypass_rd1", RD1, 32'h20);
    check("bypass_rd2", RD2, 32'h20);
    @(posedge clk); #1;
    @(negedge clk); idle(); #1;
    check("x7_after", RD1, 32'h20);
    check("bypass_count", WriteCount, 32'd6);

    // Store only leaves x9 alone
    @(negedge clk); idle();
    MemWriteW = 1; RdW = 9; ALUResultW = 32'h55; A1 = 9;
    @(posedge clk); #1;
    @(negedge clk); idle(); #1;
    check("store_x9", RD1, 32'h0);
    check("store_count", WriteCount, 32'd6);

    // Reset held across an edge discards the commit at that edge
    @(negedge clk); idle();
    RegWriteW = 1; RdW = 10; ALUResultW = 32'hCAFE; reset = 1;
    @(posedge clk); #1;
    @(negedge clk); idle(); reset = 0; A1 = 10; #1;
    check("reset_discard_x10", RD1, 32'h0);
    check("reset_discard_count", WriteCount, 32'h0);

    // Counter wrap
    @(negedge clk);
    force dut.writeCnt = 32'hFFFFFFFE;
    #1 release dut.writeCnt;
    #1 check("wrap_preload", WriteCount, 32'hFFFFFFFE);
    commitAlu(3, 32'h31);
    check("wrap_ffffffff", WriteCount, 32'hFFFFFFFF);
    commitAlu(3, 32'h32);
    check("wrap_zero", WriteCount, 32'h0);
    commitAlu(3, 32'h33);
    check("wrap_one", WriteCount, 32'h1);
    @(negedge clk); idle(); A1 = 3; #1;
    check("x3_last_wins", RD1, 32'h33);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/wb_regfile.md
# wb_regfile

Writeback-stage consumer for the pipelined RISC-V core. Takes the W-stage control bits (RegWriteW, ResultSrcW) and datapath values registered by the MEM/WB boundary, selects the writeback result, and commits it to a 32-entry integer register file. Serves the two decode-stage read ports, with same-cycle write-to-read bypass. Keeps a free-running count of committed register writes for performance monitoring.

## Interface
- XLEN, 32, data width of registers, result and read ports
- NREG, 32, number of architectural registers; index width is log2(NREG) = 5

- clk  in  1  single clock; all state updates on rising edge
- reset  in  1  asynchronous, active-high; clears all state immediately
- RegWriteW  in  1  commit ResultW to register RdW this cycle
- MemWriteW  in  1  accepted for interface completeness; has no effect in this block
- ResultSrcW  in  2  result select: 00 ALU, 01 load data, 10 PC+4, 11 reserved
- RdW  in  5  destination register index
- ALUResultW  in  XLEN  ALU result from MEM/WB
- ReadDataW  in  XLEN  load data from MEM/WB
- PCPlus4W  in  XLEN  link value from MEM/WB
- A1  in  5  read port 1 index (Rs1D)
- A2  in  5  read port 2 index (Rs2D)
- RD1  out  XLEN  read port 1 data, combinational
- RD2  out  XLEN  read port 2 data, combinational
- ResultW  out  XLEN  selected writeback value, combinational; also feeds the EX forwarding path
- WriteCount  out  32  committed-write counter

## Operation
- Result mux: 00 -> ALUResultW; 01 -> ReadDataW; 10 -> PCPlus4W; 11 -> ALUResultW (reserved encoding aliases 00).
- Commit condition: RegWriteW == 1 and RdW != 0. On commit, regs[RdW] <= ResultW at the rising edge of clk.
- x0 is hardwired: never stored; reads of index 0 always return 0. This includes a read of index 0 in the same cycle as an attempted write to RdW == 0.
- Bypass: if the commit condition holds and A1 == RdW, then RD1 = ResultW. Otherwise RD1 = regs[A1]. RD2 follows the same rule against A2. Decode therefore sees the value being written in the same cycle, with no half-cycle write required.
- A1 == A2 == RdW with a commit: both ports return ResultW.
- WriteCount increments by 1 on every commit and wraps from 0xFFFFFFFF to 0. It does not increment when RegWriteW == 1 and RdW == 0.
- MemWriteW is ignored. Stores never write the register file unless RegWriteW is also asserted.

## Timing
- Reset is asynchronous. While reset is high:
  - regs[1..31] = 0 and WriteCount = 0.
  - RD1 and RD2 read 0 unless bypassed.
  - A commit present when reset deasserts takes effect on the first rising edge after deassertion.
- Reset asserted mid-operation discards any commit in flight at that edge; the register stays 0.
- Write latency: 1 edge. The value is visible through the array on the cycle after commit and through the bypass in the same cycle.
- Read latency: 0. RD1, RD2 and ResultW are purely combinational from inputs and array state.
- Back-to-back commits to the same RdW: the last edge wins. The bypass always reflects the current cycle's ResultW.
- WriteCount updates on the same edge as the array write.

## Test plan
- Reset: pulse reset mid-cycle after writing x5 = 0x1234 -> RD1 (A1 = 5) reads 0 immediately; WriteCount = 0.
- Source select, each committed to x1..x4 in turn:
  - ResultSrcW = 00, ALUResultW = 0xA5A5A5A5
  - ResultSrcW = 01, ReadDataW = 0xDEADBEEF
  - ResultSrcW = 10, PCPlus4W = 0x00000104
  - ResultSrcW = 11, ALUResultW = 0x77
  - -> the next cycle reads 0xA5A5A5A5, 0xDEADBEEF, 0x104 and 0x77; WriteCount = 4.
- x0: RegWriteW = 1, RdW = 0, ResultW = 0xFFFFFFFF, A1 = 0 -> RD1 = 0 in the same and the following cycle; WriteCount unchanged.
- Bypass: x7 holds 0x10; commit x7 = 0x20 with A1 = A2 = 7 -> RD1 = RD2 = 0x20 in the same cycle; with RegWriteW = 0 the same setup gives 0x10.
- Store only: MemWriteW = 1, RegWriteW = 0, RdW = 9, ALUResultW = 0x55 -> x9 unchanged; WriteCount unchanged.
- Counter wrap: force WriteCount to 0xFFFFFFFE, then perform 3 commits to x3 -> count goes 0xFFFFFFFF, 0, 1.
